// File: rtl/lmsm_sequencer_if.sv
// IF/ID-to-ID/RR handshake for the LM/SM micro-op sequencer.
// The pipeline side drives the instruction and stall controls; the sequencer drives the micro-op.
interface lmsm_sequencer_if;
    logic [15:0] Inst;
    logic        valid;
    logic        hold;
    logic        flush;
    logic [2:0]  LM_RegRd;
    logic [15:0] seq_offset;
    logic        seq_valid;
    logic        seq_last;
    logic        IFID_hold;
    logic        busy;

    modport master (
        output Inst, valid, hold, flush,
        input  LM_RegRd, seq_offset, seq_valid, seq_last, IFID_hold, busy
    );

    modport slave (
        input  Inst, valid, hold, flush,
        output LM_RegRd, seq_offset, seq_valid, seq_last, IFID_hold, busy
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Splits LM/SM register-list instructions into one register micro-op per cycle.
//   state | meaning
//   IDLE  | decoding IF/ID directly; first (or only) micro-op issued from Inst[7:0]
//   SEQ   | issuing remaining micro-ops from the pending mask, IF/ID frozen
module lmsm_sequencer (
    input  logic             clock,
    input  logic             reset_n,
    lmsm_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, SEQ} state_t;

    state_t      state, state_nx;
    logic [7:0]  mask, mask_nx;
    logic [2:0]  cnt, cnt_nx;

    logic [7:0]  list;
    logic [7:0]  low_bit;
    logic [2:0]  low_idx;
    logic        is_lmsm;
    logic        multi;

    logic [2:0]  reg_rd;
    logic [15:0] offset;
    logic        sv, last, ih, bsy;

    // Inst[11:8] carries fields the sequencer never needs.
    logic unused_inst;
    assign unused_inst = ^bus.Inst[11:8];

    assign is_lmsm = (bus.Inst[15:12] == 4'b0110) || (bus.Inst[15:12] == 4'b0111);
    assign list    = (state == IDLE) ? bus.Inst[7:0] : mask;
    assign low_bit = list & (~list + 8'd1);
    assign multi   = |(list & (list - 8'd1));

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (list[i]) low_idx = i[2:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            mask  <= 8'd0;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            mask  <= mask_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        mask_nx  = mask;
        cnt_nx   = cnt;
        reg_rd   = 3'd0;
        offset   = 16'd0;
        sv       = 1'b0;
        last     = 1'b0;
        ih       = 1'b0;
        bsy      = (state == SEQ);

        if (state == IDLE) begin
            if (!is_lmsm) begin
                sv   = bus.valid;
                last = 1'b1;
            end else if (list == 8'd0) begin
                last = 1'b1;
            end else begin
                sv     = bus.valid;
                reg_rd = low_idx;
                last   = !multi;
                ih     = bus.valid && multi;
            end
            if (bus.valid && is_lmsm && multi) begin
                state_nx = SEQ;
                mask_nx  = list & ~low_bit;
                cnt_nx   = 3'd1;
            end
        end else begin
            sv     = 1'b1;
            reg_rd = low_idx;
            offset = {13'd0, cnt};
            last   = !multi;
            ih     = multi;
            if (multi) begin
                mask_nx = mask & ~low_bit;
                cnt_nx  = cnt + 3'd1;
            end else begin
                state_nx = IDLE;
                mask_nx  = 8'd0;
                cnt_nx   = 3'd0;
            end
        end

        // Downstream stall freezes state, but outputs keep their decoded values.
        if (bus.hold) begin
            state_nx = state;
            mask_nx  = mask;
            cnt_nx   = cnt;
        end

        if (bus.flush) begin
            sv       = 1'b0;
            ih       = 1'b0;
            state_nx = IDLE;
            mask_nx  = 8'd0;
            cnt_nx   = 3'd0;
        end

        // Reset must quiet the outputs without waiting for a clock edge.
        if (!reset_n) begin
            reg_rd = 3'd0;
            offset = 16'd0;
            sv     = 1'b0;
            last   = 1'b0;
            ih     = 1'b0;
            bsy    = 1'b0;
        end
    end

    assign bus.LM_RegRd   = reg_rd;
    assign bus.seq_offset = offset;
    assign bus.seq_valid  = sv;
    assign bus.seq_last   = last;
    assign bus.IFID_hold  = ih;
    assign bus.busy       = bsy;
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: directed scenarios plus randomized traffic against a list-position model.
module tb_lmsm_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    lmsm_sequencer_if bus();

    lmsm_sequencer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit op_is_lmsm(input logic [15:0] inst);
        return (inst[15:12] == 4'h6) || (inst[15:12] == 4'h7);
    endfunction

    // k-th set bit (ascending) of a register list
    function automatic int nth_bit(input logic [7:0] lst, input int k);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            if (lst[i]) begin
                if (c == k) return i;
                c++;
            end
        end
        return 0;
    endfunction

    // Model: the instruction's full register list and the position of the current micro-op.
    bit         m_seq = 1'b0;
    logic [7:0] m_list = 8'd0;
    int         m_n = 0;
    int         m_pos = 0;
    bit         m_ih = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_seq <= 1'b0;
        end else if (bus.flush) begin
            m_seq <= 1'b0;
        end else if (!bus.hold) begin
            if (m_seq) begin
                if (m_pos == m_n - 1) m_seq <= 1'b0;
                else m_pos <= m_pos + 1;
            end else if (bus.valid && op_is_lmsm(bus.Inst) && $countones(bus.Inst[7:0]) >= 2) begin
                m_seq  <= 1'b1;
                m_list <= bus.Inst[7:0];
                m_n    <= $countones(bus.Inst[7:0]);
                m_pos  <= 1;
            end
        end
    end

    always @(negedge clock) begin
        int  e_reg, e_off, n;
        bit  e_sv, e_last, e_ih, e_busy, detail;
        e_reg = 0; e_off = 0; e_sv = 0; e_last = 0; e_ih = 0; e_busy = 0; detail = 1;
        if (!reset_n) begin
            detail = 1;
        end else if (m_seq) begin
            e_reg = nth_bit(m_list, m_pos); e_off = m_pos; e_sv = 1;
            e_last = (m_pos == m_n - 1); e_ih = (m_pos < m_n - 1); e_busy = 1;
        end else if (!op_is_lmsm(bus.Inst)) begin
            e_sv = bus.valid; e_last = 1;
        end else begin
            n = $countones(bus.Inst[7:0]);
            if (n == 0) begin
                e_last = 1; detail = 0;
            end else begin
                e_sv = bus.valid; e_reg = nth_bit(bus.Inst[7:0], 0);
                e_last = (n == 1); e_ih = bus.valid && (n >= 2);
                detail = bus.valid;
            end
        end
        if (reset_n && bus.flush) begin
            e_sv = 0; e_ih = 0; detail = 0;
        end
        chk("seq_valid", {15'd0, bus.seq_valid}, {15'd0, e_sv});
        chk("IFID_hold", {15'd0, bus.IFID_hold}, {15'd0, e_ih});
        chk("busy", {15'd0, bus.busy}, {15'd0, e_busy});
        if (detail) begin
            chk("LM_RegRd", {13'd0, bus.LM_RegRd}, e_reg[15:0]);
            chk("seq_offset", bus.seq_offset, e_off[15:0]);
            chk("seq_last", {15'd0, bus.seq_last}, {15'd0, e_last});
        end
        m_ih = e_ih;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic outs(input string tag, input int r, input int o, input bit sv, input bit last,
                        input bit ih, input bit busy);
        chk({tag, ".reg"}, {13'd0, bus.LM_RegRd}, r[15:0]);
        chk({tag, ".off"}, bus.seq_offset, o[15:0]);
        chk({tag, ".sv"}, {15'd0, bus.seq_valid}, {15'd0, sv});
        chk({tag, ".last"}, {15'd0, bus.seq_last}, {15'd0, last});
        chk({tag, ".ih"}, {15'd0, bus.IFID_hold}, {15'd0, ih});
        chk({tag, ".busy"}, {15'd0, bus.busy}, {15'd0, busy});
    endtask

    task automatic look(input string tag, input int r, input int o, input bit sv, input bit last,
                        input bit ih, input bit busy);
        @(negedge clock);
        outs(tag, r, o, sv, last, ih, busy);
        step();
    endtask

    initial begin
        bus.Inst = 16'h60FF; bus.valid = 1'b1; bus.hold = 1'b0; bus.flush = 1'b0;
        #3;
        outs("reset", 0, 0, 0, 0, 0, 0);
        #1 bus.valid = 1'b0;
        #8 reset_n = 1'b1;
        step();

        // LM 0xA5
        bus.Inst = 16'h60A5; bus.valid = 1'b1;
        look("a0", 0, 0, 1, 0, 1, 0);
        look("a1", 2, 1, 1, 0, 1, 1);
        look("a2", 5, 2, 1, 0, 1, 1);
        look("a3", 7, 3, 1, 1, 0, 1);

        // SM single register
        bus.Inst = 16'h7010;
        look("b0", 4, 0, 1, 1, 0, 0);

        // LM empty list is a bubble
        bus.Inst = 16'h6000;
        @(negedge clock);
        chk("c0.sv", {15'd0, bus.seq_valid}, 16'd0);
        chk("c0.ih", {15'd0, bus.IFID_hold}, 16'd0);
        chk("c0.last", {15'd0, bus.seq_last}, 16'd1);
        step();
        bus.Inst = 16'h1234;
        look("c1", 0, 0, 1, 1, 0, 0);

        // LM 0xFF with hold on R2
        bus.Inst = 16'h60FF;
        look("d0", 0, 0, 1, 0, 1, 0);
        look("d1", 1, 1, 1, 0, 1, 1);
        bus.hold = 1'b1;
        look("d2h1", 2, 2, 1, 0, 1, 1);
        look("d2h2", 2, 2, 1, 0, 1, 1);
        bus.hold = 1'b0;
        look("d2", 2, 2, 1, 0, 1, 1);
        for (int k = 3; k < 8; k++) look($sformatf("d%0d", k), k, k, 1, k == 7, k != 7, 1);

        // SM 0xFF flushed on R3
        bus.Inst = 16'h70FF;
        look("e0", 0, 0, 1, 0, 1, 0);
        look("e1", 1, 1, 1, 0, 1, 1);
        look("e2", 2, 2, 1, 0, 1, 1);
        bus.flush = 1'b1;
        @(negedge clock);
        chk("e3.sv", {15'd0, bus.seq_valid}, 16'd0);
        chk("e3.ih", {15'd0, bus.IFID_hold}, 16'd0);
        step();
        bus.flush = 1'b0; bus.valid = 1'b0; bus.Inst = 16'h0000;
        @(negedge clock);
        chk("e4.busy", {15'd0, bus.busy}, 16'd0);
        chk("e4.sv", {15'd0, bus.seq_valid}, 16'd0);
        step();

        // Reset pulse during R5
        bus.Inst = 16'h60FF; bus.valid = 1'b1;
        for (int k = 0; k < 5; k++) look($sformatf("f%0d", k), k, k, 1, 0, 1, k != 0);
        @(negedge clock);
        outs("f5", 5, 5, 1, 0, 1, 1);
        #1 reset_n = 1'b0;
        #1 outs("frst", 0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b1;
        #1 outs("frel", 0, 0, 1, 0, 1, 0);
        step();
        outs("fnext", 1, 1, 1, 0, 1, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.valid = 1'b0;
        step();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (!m_ih) begin
                logic [3:0] op;
                logic [7:0] lst;
                int r;
                r = int'($urandom_range(0, 7));
                op = (r < 3) ? 4'h6 : (r < 6) ? 4'h7 : 4'($urandom);
                r = int'($urandom_range(0, 5));
                lst = (r == 0) ? 8'h00 : (r == 1) ? (8'd1 << $urandom_range(0, 7)) :
                      (r == 2) ? 8'hFF : 8'($urandom);
                bus.Inst  = {op, 4'($urandom), lst};
                bus.valid = ($urandom_range(0, 4) != 0);
            end
            bus.hold  = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
